test_sequencer: RTL and testbench

Synthesizable, parametrised test sequencer for on-target self-test of peripherals such as the video block. It runs up to NUM_TESTS hardware test engines in ascending index order and skips masked slots. Before each test it holds the DUT in reset, then hands control to one engine, counts that engine's pass/fail check pulses, and enforces a per-test watchdog. Results stay readable after the run through an indexed read port.

---
 rtl/test_sequencer.sv | 151 +++++++++++++++
 tb/tb_test_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// test_sequencer: runs masked hardware test engines in order, with DUT reset, pass/fail counting and a watchdog
module test_sequencer #(
    parameter int NUM_TESTS      = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT        = 100000,
    parameter int DUT_RST_CYCLES = 4,
    localparam int IW            = NUM_TESTS > 1 ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_TESTS-1:0] test_mask,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_pass,
    input  logic [NUM_TESTS-1:0] test_fail,
    output logic                 dut_reset_n,
    output logic [NUM_TESTS-1:0] test_go,
    output logic                 busy,
    output logic                 all_done,
    output logic [IW-1:0]        cur_test,
    input  logic [IW-1:0]        rd_idx,
    output logic [CNT_W-1:0]     rd_pass,
    output logic [CNT_W-1:0]     rd_fail,
    output logic                 rd_timeout,
    output logic                 total_fail_nz
);
    localparam int IW1 = IW + 1;
    localparam int CW1 = CNT_W + 1;
    localparam int WW  = $clog2(TIMEOUT + 1);
    localparam int RW  = $clog2(DUT_RST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SEL, DUT_RST, RUN, DONE} state_t;

    state_t               state;
    logic [NUM_TESTS-1:0] mask;
    logic [IW:0]          idx;
    logic [WW-1:0]        wd;
    logic [RW-1:0]        rst_cnt;
    logic [CNT_W-1:0]     pass_cnt [NUM_TESTS];
    logic [CNT_W-1:0]     fail_cnt [NUM_TESTS];
    logic [NUM_TESTS-1:0] tmo;
    logic                 found;
    logic [IW-1:0]        nxt;
    logic                 expire;
    logic [CNT_W:0]       p_sum;
    logic [CNT_W:0]       f_sum;
    logic [CNT_W-1:0]     p_nxt;
    logic [CNT_W-1:0]     f_nxt;

    // descending scan so the lowest enabled slot at or above idx wins
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--)
            if (mask[i] && IW1'(i) >= idx) begin
                found = 1'b1;
                nxt   = IW'(i);
            end
    end

    // a watchdog expiry adds to the fail count on top of any fail pulse that cycle
    always_comb begin
        expire = wd == WW'(TIMEOUT - 1) && !test_done[cur_test];
        p_sum  = {1'b0, pass_cnt[cur_test]} + CW1'(test_pass[cur_test]);
        f_sum  = {1'b0, fail_cnt[cur_test]} + CW1'(test_fail[cur_test]) + CW1'(expire);
        p_nxt  = p_sum[CNT_W] ? '1 : p_sum[CNT_W-1:0];
        f_nxt  = f_sum[CNT_W] ? '1 : f_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mask        <= '0;
            idx         <= '0;
            wd          <= '0;
            rst_cnt     <= '0;
            tmo         <= '0;
            cur_test    <= '0;
            dut_reset_n <= 1'b1;
            test_go     <= '0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
            for (int i = 0; i < NUM_TESTS; i++) begin
                pass_cnt[i] <= '0;
                fail_cnt[i] <= '0;
            end
        end else if (abort) begin
            state       <= IDLE;
            dut_reset_n <= 1'b1;
            test_go     <= '0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state    <= SEL;
                    mask     <= test_mask;
                    idx      <= '0;
                    tmo      <= '0;
                    busy     <= 1'b1;
                    all_done <= 1'b0;
                    for (int i = 0; i < NUM_TESTS; i++) begin
                        pass_cnt[i] <= '0;
                        fail_cnt[i] <= '0;
                    end
                end
                SEL: if (found) begin
                    state       <= DUT_RST;
                    cur_test    <= nxt;
                    rst_cnt     <= '0;
                    dut_reset_n <= 1'b0;
                end else begin
                    state    <= DONE;
                    busy     <= 1'b0;
                    all_done <= 1'b1;
                end
                DUT_RST: if (rst_cnt == RW'(DUT_RST_CYCLES - 1)) begin
                    state             <= RUN;
                    dut_reset_n       <= 1'b1;
                    test_go[cur_test] <= 1'b1;
                    wd                <= '0;
                end else begin
                    rst_cnt <= rst_cnt + 1'b1;
                end
                RUN: begin
                    pass_cnt[cur_test] <= p_nxt;
                    fail_cnt[cur_test] <= f_nxt;
                    if (test_done[cur_test] || expire) begin
                        state         <= SEL;
                        test_go       <= '0;
                        idx           <= IW1'(cur_test) + 1'b1;
                        tmo[cur_test] <= tmo[cur_test] | expire;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_pass    = pass_cnt[rd_idx];
    assign rd_fail    = fail_cnt[rd_idx];
    assign rd_timeout = tmo[rd_idx];

    always_comb begin
        total_fail_nz = |tmo;
        for (int i = 0; i < NUM_TESTS; i++) total_fail_nz = total_fail_nz | (|fail_cnt[i]);
    end
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: directed scenarios checked every cycle against a slot-queue/segment-timer model
module tb_test_sequencer;
    localparam int N  = 8;
    localparam int CW = 4;
    localparam int TO = 16;
    localparam int D  = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] test_mask = '0;
    logic [N-1:0] test_done = '0;
    logic [N-1:0] test_pass = '0;
    logic [N-1:0] test_fail = '0;
    logic         dut_reset_n;
    logic [N-1:0] test_go;
    logic         busy;
    logic         all_done;
    logic [2:0]   cur_test;
    logic [2:0]   rd_idx = '0;
    logic [CW-1:0] rd_pass;
    logic [CW-1:0] rd_fail;
    logic         rd_timeout;
    logic         total_fail_nz;

    test_sequencer #(.NUM_TESTS(N), .CNT_W(CW), .TIMEOUT(TO), .DUT_RST_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .test_mask(test_mask), .test_done(test_done), .test_pass(test_pass), .test_fail(test_fail),
        .dut_reset_n(dut_reset_n), .test_go(test_go), .busy(busy), .all_done(all_done),
        .cur_test(cur_test), .rd_idx(rd_idx), .rd_pass(rd_pass), .rd_fail(rd_fail),
        .rd_timeout(rd_timeout), .total_fail_nz(total_fail_nz)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rd_force = -1;
    int last_hi = 0;

    // model: 0 idle, 1 sequencing, 2 done; seg = cycles into the current slot (0 select, 1..D reset, >D run)
    int m_mode = 0;
    int q[$];
    int seg = 0;
    int m_cur = 0;
    int m_pass [N];
    int m_fail [N];
    bit m_tmo [N];

    function automatic int sat(input int v);
        return v > (1 << CW) - 1 ? (1 << CW) - 1 : v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", n, $time, a, e);
        end
    endtask

    initial begin
        foreach (m_pass[i]) begin m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0; end
        forever begin
            int s;
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_mode = 0; q.delete(); seg = 0; m_cur = 0;
                foreach (m_pass[i]) begin m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0; end
            end else if (abort) begin
                m_mode = 0;
            end else if (m_mode != 1) begin
                if (start) begin
                    foreach (m_pass[i]) begin m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0; end
                    q.delete();
                    for (int i = 0; i < N; i++) if (test_mask[i]) q.push_back(i);
                    seg = 0; m_mode = 1;
                end
            end else if (q.size() == 0) begin
                m_mode = 2;
            end else if (seg == 0) begin
                m_cur = q[0]; seg = 1;
            end else if (seg <= D) begin
                seg++;
            end else begin
                s = q[0];
                m_pass[s] = sat(m_pass[s] + int'(test_pass[s]));
                m_fail[s] = sat(m_fail[s] + int'(test_fail[s]));
                if (test_done[s]) begin
                    void'(q.pop_front()); seg = 0;
                end else if (seg - D - 1 == TO - 1) begin
                    m_tmo[s] = 1; m_fail[s] = sat(m_fail[s] + 1);
                    void'(q.pop_front()); seg = 0;
                end else seg++;
            end
        end
    end

    // per-cycle compare plus pulse-length monitors
    initial begin
        int hi_run = 0, zero_run = 0, low_run = 0;
        bit had_fall = 0, prev_rstn = 1;
        logic [N-1:0] prev_go = '0;
        forever begin
            int eg;
            bit er, nz;
            @(negedge clk);
            eg = (m_mode == 1 && q.size() > 0 && seg > D) ? (1 << q[0]) : 0;
            er = !(m_mode == 1 && q.size() > 0 && seg >= 1 && seg <= D);
            nz = 0;
            for (int i = 0; i < N; i++) nz |= (m_fail[i] != 0) || m_tmo[i];
            chk("dut_reset_n", 32'(dut_reset_n), 32'(er));
            chk("test_go", 32'(test_go), eg);
            chk("busy", 32'(busy), 32'(m_mode == 1));
            chk("all_done", 32'(all_done), 32'(m_mode == 2));
            chk("cur_test", 32'(cur_test), m_cur);
            chk("rd_pass", 32'(rd_pass), m_pass[rd_idx]);
            chk("rd_fail", 32'(rd_fail), m_fail[rd_idx]);
            chk("rd_timeout", 32'(rd_timeout), 32'(m_tmo[rd_idx]));
            chk("total_fail_nz", 32'(total_fail_nz), 32'(nz));
            if (!dut_reset_n) low_run = prev_rstn ? 1 : low_run + 1;
            if (!busy) had_fall = 0;
            if (test_go != 0) begin
                if (prev_go == 0) begin
                    chk("rst_low_len", low_run, D);
                    if (had_fall) chk("gap_len", zero_run, D + 1);
                end
                hi_run++; zero_run = 0;
            end else begin
                if (prev_go != 0) begin last_hi = hi_run; had_fall = 1; end
                hi_run = 0; zero_run++;
            end
            prev_go = test_go;
            prev_rstn = dut_reset_n;
            rd_idx = rd_force >= 0 ? 3'(rd_force) : rd_idx + 3'd1;
        end
    end

    task automatic start_run(input logic [N-1:0] m);
        test_mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_go(input int s);
        int k = 0;
        while (test_go[s] !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        chk($sformatf("wait_go[%0d]", s), 32'(test_go[s]), 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (all_done !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        chk("wait_done", 32'(all_done), 1);
    endtask

    task automatic rd_chk(input int i, input int p, input int f, input int t);
        rd_force = i;
        repeat (2) @(negedge clk);
        #1;
        chk($sformatf("lit_rd_pass[%0d]", i), 32'(rd_pass), p);
        chk($sformatf("lit_rd_fail[%0d]", i), 32'(rd_fail), f);
        chk($sformatf("lit_rd_timeout[%0d]", i), 32'(rd_timeout), t);
        rd_force = -1;
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        #1;
        chk("lit_reset_rstn", 32'(dut_reset_n), 1);
        chk("lit_reset_go", 32'(test_go), 0);
        chk("lit_reset_busy", 32'(busy), 0);
        chk("lit_reset_done", 32'(all_done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        // all-zero mask: SEL then DONE, all_done at cycle 2
        start_run('0);
        chk("lit_zero_busy_c1", 32'(busy), 1);
        chk("lit_zero_done_c1", 32'(all_done), 0);
        @(negedge clk);
        chk("lit_zero_done_c2", 32'(all_done), 1);
        // mask 0000_0101: slot 0 3/0, slot 2 1/2 with a simultaneous pulse and a stray slot-5 fail
        start_run(8'h05);
        wait_go(0);
        test_pass[0] = 1'b1;
        repeat (3) @(negedge clk);
        test_pass[0] = 1'b0; test_done[0] = 1'b1;
        @(negedge clk);
        test_done[0] = 1'b0;
        wait_go(2);
        test_pass[2] = 1'b1; test_fail[2] = 1'b1; test_fail[5] = 1'b1;
        @(negedge clk);
        test_pass[2] = 1'b0;
        @(negedge clk);
        test_fail[2] = 1'b0; test_fail[5] = 1'b0; test_done[2] = 1'b1;
        @(negedge clk);
        test_done[2] = 1'b0;
        wait_done();
        chk("lit_model_pass0", m_pass[0], 3);
        chk("lit_model_fail2", m_fail[2], 2);
        rd_chk(0, 3, 0, 0);
        rd_chk(2, 1, 2, 0);
        rd_chk(1, 0, 0, 0);
        rd_chk(5, 0, 0, 0);
        chk("lit_total_nz_1", 32'(total_fail_nz), 1);
        // watchdog on slot 1
        start_run(8'h02);
        wait_done();
        chk("lit_timeout_go_len", last_hi, TO);
        rd_chk(1, 0, 1, 1);
        rd_chk(0, 0, 0, 0);
        chk("lit_total_nz_2", 32'(total_fail_nz), 1);
        // done coincides with expiry: done wins
        start_run(8'h08);
        wait_go(3);
        repeat (TO - 1) @(negedge clk);
        test_done[3] = 1'b1;
        @(negedge clk);
        test_done[3] = 1'b0;
        wait_done();
        chk("lit_coinc_go_len", last_hi, TO);
        rd_chk(3, 0, 0, 0);
        chk("lit_total_nz_3", 32'(total_fail_nz), 0);
        // saturation on slot 4, stray fails on slot 6 while slot 5 runs
        start_run(8'h30);
        wait_go(4);
        test_pass[4] = 1'b1;
        k = 0;
        while (test_go[4] === 1'b1 && k < 100) begin @(negedge clk); k++; end
        test_pass[4] = 1'b0;
        wait_go(5);
        test_fail[6] = 1'b1;
        repeat (3) @(negedge clk);
        test_done[5] = 1'b1;
        @(negedge clk);
        test_done[5] = 1'b0; test_fail[6] = 1'b0;
        wait_done();
        chk("lit_model_sat", m_pass[4], 15);
        rd_chk(4, 15, 1, 1);
        rd_chk(5, 0, 0, 0);
        rd_chk(6, 0, 0, 0);
        // abort mid-RUN, with an ignored start
        start_run(8'h03);
        wait_go(0);
        test_pass[0] = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        test_pass[0] = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("lit_abort_busy", 32'(busy), 0);
        chk("lit_abort_go", 32'(test_go), 0);
        chk("lit_abort_done", 32'(all_done), 0);
        rd_chk(0, 2, 0, 0);
        // asynchronous reset during DUT_RST
        start_run(8'h80);
        k = 0;
        while (dut_reset_n !== 1'b0 && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        chk("lit_pre_rst_cur", 32'(cur_test), 7);
        #2 reset_n = 1'b0;
        #1;
        chk("lit_arst_rstn", 32'(dut_reset_n), 1);
        chk("lit_arst_go", 32'(test_go), 0);
        chk("lit_arst_busy", 32'(busy), 0);
        chk("lit_arst_done", 32'(all_done), 0);
        chk("lit_arst_cur", 32'(cur_test), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
